// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, aligner states and the word decoder.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH,
        SLIP,
        SETTLE,
        LOCKED
    } align_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       is_ctrl;
    } tmds_dec_t;

    // Control tokens yield ctrl with data=0; anything else is undone as
    // transition-minimised data (no disparity or TERC4 handling).
    function automatic tmds_dec_t tmds_decode(input logic [9:0] w);
        tmds_dec_t  r;
        logic [7:0] q;
        logic [6:0] x;
        r = '0;
        q = w[9] ? ~w[7:0] : w[7:0];
        x = q[7:1] ^ q[6:0];
        case (w)
            TOK_C00: begin r.ctrl = 2'b00; r.is_ctrl = 1'b1; end
            TOK_C01: begin r.ctrl = 2'b01; r.is_ctrl = 1'b1; end
            TOK_C10: begin r.ctrl = 2'b10; r.is_ctrl = 1'b1; end
            TOK_C11: begin r.ctrl = 2'b11; r.is_ctrl = 1'b1; end
            default: r.data = {(w[8] ? x : ~x), q[0]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Word-boundary search: counts consecutive control tokens, slips the
// deserializer on timeout, and watches for token loss once locked.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT     = 16,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_SETTLE    = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_is_ctrl,
    output logic o_bitslip,
    output logic o_aligned,
    output logic o_lock_nxt
);

    localparam int RW = $clog2(LOCK_COUNT) + 1;
    localparam int TW = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int SW = $clog2(SLIP_SETTLE) + 1;

    localparam logic [RW-1:0] RUN_LAST    = RW'(LOCK_COUNT - 1);
    localparam logic [RW-1:0] RUN_FULL    = RW'(LOCK_COUNT);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(SEARCH_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SLIP_SETTLE - 1);

    align_state_t  state, state_n;
    logic [RW-1:0] run_cnt, run_n;
    logic [TW-1:0] timer, timer_n;
    logic [SW-1:0] settle_cnt, settle_n;

    // State and counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= SEARCH;
            run_cnt    <= '0;
            timer      <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_n;
            run_cnt    <= run_n;
            timer      <= timer_n;
            settle_cnt <= settle_n;
        end
    end

    // Next state; lock is tested before timeout, and in LOCKED a token beats expiry
    always_comb begin
        state_n  = state;
        run_n    = run_cnt;
        timer_n  = timer;
        settle_n = settle_cnt;
        case (state)
            SEARCH: begin
                timer_n = (timer != TIMER_LAST) ? timer + TW'(1) : timer;
                if (i_is_ctrl)
                    run_n = (run_cnt != RUN_FULL) ? run_cnt + RW'(1) : run_cnt;
                else
                    run_n = '0;
                if (i_is_ctrl && run_cnt == RUN_LAST) begin
                    state_n = LOCKED;
                    timer_n = '0;
                end else if (timer == TIMER_LAST) begin
                    state_n = SLIP;
                end
            end
            SLIP: begin
                state_n  = SETTLE;
                settle_n = '0;
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_n = SEARCH;
                    run_n   = '0;
                    timer_n = '0;
                end else begin
                    settle_n = settle_cnt + SW'(1);
                end
            end
            LOCKED: begin
                if (i_is_ctrl) begin
                    timer_n = '0;
                end else if (timer == TIMER_LAST) begin
                    state_n = SEARCH;
                    run_n   = '0;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    assign o_bitslip  = (state == SLIP);
    assign o_aligned  = (state == LOCKED);
    assign o_lock_nxt = (state_n == LOCKED);

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel: boundary alignment plus registered word decode.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT     = 16,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_SETTLE    = 4
) (
    input  logic       i_pix_clk,
    input  logic       i_rst,
    input  logic [9:0] i_tmds_word,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_de,
    output logic       o_bitslip,
    output logic       o_aligned
);

    tmds_dec_t dec;
    logic      lock_nxt;
    logic      de_nxt;

    assign dec    = tmds_decode(i_tmds_word);
    // Gate with the post-edge alignment so o_de never outlives o_aligned.
    assign de_nxt = lock_nxt & ~dec.is_ctrl;

    tmds_word_aligner #(
        .LOCK_COUNT    (LOCK_COUNT),
        .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
        .SLIP_SETTLE   (SLIP_SETTLE)
    ) u_aligner (
        .i_clk     (i_pix_clk),
        .i_rst     (i_rst),
        .i_is_ctrl (dec.is_ctrl),
        .o_bitslip (o_bitslip),
        .o_aligned (o_aligned),
        .o_lock_nxt(lock_nxt)
    );

    // Output stage; ctrl holds through data periods
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            o_data <= '0;
            o_ctrl <= '0;
            o_de   <= 1'b0;
        end else begin
            o_data <= de_nxt ? dec.data : 8'h00;
            o_ctrl <= dec.is_ctrl ? dec.ctrl : o_ctrl;
            o_de   <= de_nxt;
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench with a rotating-boundary deserializer model.
module tb_tmds_channel_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] word;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic       o_de, o_bitslip, o_aligned;

    always #5 clk = ~clk;

    tmds_channel_decoder #(
        .LOCK_COUNT(16), .SEARCH_TIMEOUT(4096), .SLIP_SETTLE(4)
    ) dut (
        .i_pix_clk  (clk),
        .i_rst      (rst),
        .i_tmds_word(word),
        .o_data     (o_data),
        .o_ctrl     (o_ctrl),
        .o_de       (o_de),
        .o_bitslip  (o_bitslip),
        .o_aligned  (o_aligned)
    );

    typedef struct {
        logic [9:0] w;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       de;
    } vec_t;

    int checks = 0, errors = 0;
    // deserializer model state
    logic [9:0] cur = '0, prev = '0;
    int offs = 0;
    int cycle = 0, slips = 0, last_slip = -1000, min_gap = 1000000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one serial word through the boundary model, then wait to the next negedge.
    task automatic cyc(input logic [9:0] w);
        logic [19:0] x;
        prev = cur;
        cur  = w;
        x    = {cur, prev} >> (10 - offs);
        word = x[9:0];
        @(negedge clk);
        cycle++;
        if (o_bitslip === 1'b1) begin
            slips++;
            if (cycle - last_slip < min_gap) min_gap = cycle - last_slip;
            last_slip = cycle;
            offs = (offs == 0) ? 9 : offs - 1;
        end
    endtask

    vec_t tbl[8];
    int   lock_cycle, slips_at_lock, after;
    bit   found;

    initial begin
        tbl[0] = '{10'h100, 8'h00, 2'b00, 1'b1};
        tbl[1] = '{10'h200, 8'hFF, 2'b00, 1'b1};
        tbl[2] = '{10'h1FF, 8'h01, 2'b00, 1'b1};
        tbl[3] = '{10'h000, 8'hFE, 2'b00, 1'b1};
        tbl[4] = '{10'h1A5, 8'hEF, 2'b00, 1'b1};
        tbl[5] = '{10'h2F0, 8'hEF, 2'b00, 1'b1};
        tbl[6] = '{10'h310, 8'h31, 2'b00, 1'b1};
        tbl[7] = '{10'h155, 8'hFF, 2'b00, 1'b1};

        // 1: reset with random input
        rst = 1'b1;
        word = '0;
        for (int i = 0; i < 3; i++) begin
            cyc(10'($urandom));
            chk("rst_data", o_data, 0);
            chk("rst_ctrl", o_ctrl, 0);
            chk("rst_de", o_de, 0);
            chk("rst_bitslip", o_bitslip, 0);
            chk("rst_aligned", o_aligned, 0);
        end

        // 2: aligned tokens then the decode table
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc(10'h354);
            if (k == 15) chk("t2_aligned_15", o_aligned, 0);
            if (k == 16) begin
                chk("t2_aligned_16", o_aligned, 1);
                chk("t2_ctrl", o_ctrl, 2'b00);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].w);
            chk($sformatf("tbl%0d_data", i), o_data, tbl[i].data);
            chk($sformatf("tbl%0d_ctrl", i), o_ctrl, tbl[i].ctrl);
            chk($sformatf("tbl%0d_de", i), o_de, tbl[i].de);
        end

        // 5: control values on successive cycles
        cyc(10'h2AB); chk("t5_ctrl11", o_ctrl, 2'b11); chk("t5_de0", o_de, 0);
        cyc(10'h0AB); chk("t5_ctrl01", o_ctrl, 2'b01); chk("t5_de1", o_de, 0);
        cyc(10'h154); chk("t5_ctrl10", o_ctrl, 2'b10); chk("t5_de2", o_de, 0);
        chk("t5_aligned", o_aligned, 1);

        // 4: token starvation, lock loss, relock
        slips = 0;
        for (int k = 1; k <= 5000; k++) begin
            cyc(10'h100);
            if (k == 4095) begin
                chk("t4_aligned_4095", o_aligned, 1);
                chk("t4_de_4095", o_de, 1);
            end
            if (k == 4096) begin
                chk("t4_aligned_4096", o_aligned, 0);
                chk("t4_de_4096", o_de, 0);
                chk("t4_data_4096", o_data, 0);
                chk("t4_ctrl_hold", o_ctrl, 2'b10);
            end
            if (k == 5000) chk("t4_de_5000", o_de, 0);
        end
        chk("t4_no_slip", slips, 0);
        for (int k = 1; k <= 16; k++) begin
            cyc(10'h354);
            if (k == 15) chk("t4_relock_15", o_aligned, 0);
            if (k == 16) chk("t4_relock_16", o_aligned, 1);
        end
        cyc(10'h200);
        chk("t4_de_relock", o_de, 1);
        chk("t4_data_relock", o_data, 8'hFF);

        // 3: stream misaligned by 3 bits
        rst = 1'b1;
        cyc(10'h354);
        cyc(10'h354);
        rst = 1'b0;
        offs = 3; slips = 0; last_slip = -1000; min_gap = 1000000;
        lock_cycle = -1; slips_at_lock = 0; after = 0;
        for (int line = 0; line < 20 && after < 2; line++) begin
            for (int i = 0; i < 800; i++) begin
                cyc(i < 160 ? 10'h354 : 10'h100);
                if (lock_cycle < 0 && o_aligned === 1'b1) begin
                    lock_cycle = cycle;
                    slips_at_lock = slips;
                end
            end
            if (lock_cycle >= 0) after++;
        end
        chk("t3_locked", lock_cycle >= 0, 1);
        chk("t3_slips_at_lock", slips_at_lock, 3);
        chk("t3_slips_total", slips, 3);
        chk("t3_slip_gap_ge5", min_gap >= 5, 1);
        chk("t3_offset", offs, 0);
        chk("t3_aligned_end", o_aligned, 1);

        // 6: reset landing on the bitslip cycle
        rst = 1'b1;
        cyc(10'h354);
        cyc(10'h354);
        rst = 1'b0;
        offs = 3;
        found = 1'b0;
        for (int n = 0; n < 5000 && !found; n++) begin
            cyc(10'h354);
            if (o_bitslip === 1'b1) found = 1'b1;
        end
        chk("t6_slip_seen", found, 1);
        rst = 1'b1;
        offs = 0;
        cyc(10'h354);
        chk("t6_bitslip_low", o_bitslip, 0);
        chk("t6_aligned_low", o_aligned, 0);
        chk("t6_ctrl_reset", o_ctrl, 0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc(10'h354);
            if (o_bitslip !== 1'b0) chk("t6_no_slip", o_bitslip, 0);
            if (k == 15) chk("t6_aligned_15", o_aligned, 0);
            if (k == 16) chk("t6_aligned_16", o_aligned, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
